// File: rtl/muldiv_pkg.sv
// Shared types and constants for the mult/div sequencer: FSM states, op select
// encodings and the default datapath width.
package muldiv_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_START,
        ST_WAIT,
        ST_COMMIT
    } state_t;

endpackage

// File: rtl/muldiv_if.sv
// Bundle of the control-unit request/response signals and the mult/div unit
// handshakes. The slave modport is the sequencer's view; master is the environment.
interface muldiv_if
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    // Control-unit side
    logic             op_start;
    logic             op_sel;
    logic [WIDTH-1:0] from_a;
    logic [WIDTH-1:0] from_b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_zero_exc;
    logic             timeout;

    // Datapath-unit side
    logic             unit_reset;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             mult_ctrl;
    logic             mult_done;
    logic [WIDTH-1:0] mult_hi;
    logic [WIDTH-1:0] mult_lo;
    logic             div_ctrl;
    logic             div_done;
    logic             div0;
    logic [WIDTH-1:0] div_hi;
    logic [WIDTH-1:0] div_lo;

    modport slave (
        input  op_start, op_sel, from_a, from_b,
        input  mult_done, mult_hi, mult_lo, div_done, div0, div_hi, div_lo,
        output hi, lo, busy, done, div_zero_exc, timeout,
        output unit_reset, op_a, op_b, mult_ctrl, div_ctrl
    );

    modport master (
        output op_start, op_sel, from_a, from_b,
        output mult_done, mult_hi, mult_lo, div_done, div0, div_hi, div_lo,
        input  hi, lo, busy, done, div_zero_exc, timeout,
        input  unit_reset, op_a, op_b, mult_ctrl, div_ctrl
    );

endinterface

// File: rtl/hilo_regs.sv
// Architectural HI/LO register pair; both halves load together from one write
// enable so a commit is never partial.
module hilo_regs #(
    parameter int WIDTH = muldiv_pkg::DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // NOTE: architectural state is cleared by the async reset; software may read HI/LO before any op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (we) begin
            hi <= hi_in;
            lo <= lo_in;
        end
    end

endmodule

// File: rtl/muldiv_controller.sv
// Sequencer between the control unit and the multi-cycle mult/div units.
// Optional WAIT-state watchdog is enabled by defining MULDIV_TIMEOUT_EN.
module muldiv_controller
    import muldiv_pkg::*;
#(
    parameter int WIDTH          = DEFAULT_WIDTH,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic     clk,
    input logic     rst,
    muldiv_if.slave bus
);

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t           state;
    logic             op_sel_q;
    logic [WIDTH-1:0] stage_hi;
    logic [WIDTH-1:0] stage_lo;
    logic             hilo_we;
    logic             unit_done;
    logic             div_abort;
    logic             timeout_q;

`ifdef MULDIV_TIMEOUT_EN
    localparam logic [WIDTH-1:0] TIMEOUT_LAST = WIDTH'(TIMEOUT_CYCLES - 1);
    logic [WIDTH-1:0] wait_cnt;
`endif

    assign unit_done = (op_sel_q == OP_MULT) ? bus.mult_done : bus.div_done;
    assign div_abort = (op_sel_q == OP_DIV) && bus.div0;
    assign bus.timeout = timeout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_IDLE;
            op_sel_q         <= OP_MULT;
            bus.op_a         <= '0;
            bus.op_b         <= '0;
            bus.unit_reset   <= 1'b0;
            bus.mult_ctrl    <= 1'b0;
            bus.div_ctrl     <= 1'b0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.div_zero_exc <= 1'b0;
            timeout_q        <= 1'b0;
            stage_hi         <= '0;
            stage_lo         <= '0;
            hilo_we          <= 1'b0;
`ifdef MULDIV_TIMEOUT_EN
            wait_cnt         <= '0;
`endif
        end else begin
            // NOTE: pulse outputs default low here with <=, so each case arm only states when they fire.
            bus.unit_reset   <= 1'b0;
            bus.done         <= 1'b0;
            bus.div_zero_exc <= 1'b0;
            timeout_q        <= 1'b0;
            hilo_we          <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (bus.op_start) begin
                        op_sel_q       <= bus.op_sel;
                        bus.op_a       <= bus.from_a;
                        bus.op_b       <= bus.from_b;
                        bus.unit_reset <= 1'b1;
                        bus.busy       <= 1'b1;
                        state          <= ST_CLEAR;
                    end
                end

                ST_CLEAR: begin
                    bus.mult_ctrl <= (op_sel_q == OP_MULT);
                    bus.div_ctrl  <= (op_sel_q == OP_DIV);
                    state         <= ST_START;
                end

                ST_START: begin
`ifdef MULDIV_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state <= ST_WAIT;
                end

                ST_WAIT: begin
                    // Div0 outranks DivDone: the divider's results are meaningless then.
                    if (div_abort) begin
                        bus.div_zero_exc <= 1'b1;
                        bus.done         <= 1'b1;
                        bus.mult_ctrl    <= 1'b0;
                        bus.div_ctrl     <= 1'b0;
                        state            <= ST_COMMIT;
                    end else if (unit_done) begin
                        // The divider reports quotient on HI; MIPS wants remainder in HI.
                        stage_hi      <= (op_sel_q == OP_MULT) ? bus.mult_hi : bus.div_lo;
                        stage_lo      <= (op_sel_q == OP_MULT) ? bus.mult_lo : bus.div_hi;
                        hilo_we       <= 1'b1;
                        bus.done      <= 1'b1;
                        bus.mult_ctrl <= 1'b0;
                        bus.div_ctrl  <= 1'b0;
                        state         <= ST_COMMIT;
                    end
`ifdef MULDIV_TIMEOUT_EN
                    else if (wait_cnt == TIMEOUT_LAST) begin
                        timeout_q     <= 1'b1;
                        bus.done      <= 1'b1;
                        bus.mult_ctrl <= 1'b0;
                        bus.div_ctrl  <= 1'b0;
                        state         <= ST_COMMIT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end

                ST_COMMIT: begin
                    bus.busy <= 1'b0;
                    state    <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    hilo_regs #(.WIDTH(WIDTH)) u_hilo (
        .clk   (clk),
        .rst   (rst),
        .we    (hilo_we),
        .hi_in (stage_hi),
        .lo_in (stage_lo),
        .hi    (bus.hi),
        .lo    (bus.lo)
    );

endmodule

// File: tb/tb_muldiv_controller.sv
// Directed bench for muldiv_controller: the bench plays both the control unit
// and the mult/div units. Define MULDIV_TIMEOUT_EN to add the watchdog scenario.
module tb_muldiv_controller;
    import muldiv_pkg::*;

`ifdef MULDIV_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1024;
`endif
    localparam int BUDGET = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv_controller #(.WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Issues one op (call right after a negedge) and plays the selected unit.
    // k counts negedges after the accept edge: 1 = CLEAR, 2 = START, 3 = first WAIT.
    task automatic run_op(input logic sel, input logic [31:0] a, input logic [31:0] b,
                          input int unit_cycles, input logic zero,
                          input logic [31:0] rhi, input logic [31:0] rlo, input int extra_k,
                          output int lat, output int ur_cnt, output logic exc, output logic tmo,
                          output logic ctrl_bad, output logic busy_bad,
                          output logic [31:0] seen_a, output logic [31:0] seen_b);
        logic sel_ctrl, other_ctrl;
        lat = -1; ur_cnt = 0; exc = 1'b0; tmo = 1'b0;
        ctrl_bad = 1'b0; busy_bad = 1'b0; seen_a = '0; seen_b = '0;
        bus.op_start = 1'b1; bus.op_sel = sel; bus.from_a = a; bus.from_b = b;
        for (int k = 1; k <= BUDGET; k++) begin
            @(negedge clk);
            bus.op_start = (k == extra_k);
            bus.from_a = ~a; bus.from_b = ~b;
            bus.mult_done = 1'b0; bus.div_done = 1'b0; bus.div0 = 1'b0;
            if (bus.unit_reset) ur_cnt++;
            if (!bus.busy) busy_bad = 1'b1;
            if (k == 3) begin seen_a = bus.op_a; seen_b = bus.op_b; end
            sel_ctrl   = (sel == OP_MULT) ? bus.mult_ctrl : bus.div_ctrl;
            other_ctrl = (sel == OP_MULT) ? bus.div_ctrl : bus.mult_ctrl;
            if (other_ctrl || (sel_ctrl !== ((k >= 2) && !bus.done))) ctrl_bad = 1'b1;
            if (bus.done) begin
                lat = k; exc = bus.div_zero_exc; tmo = bus.timeout;
                break;
            end
            if (k == 2 + unit_cycles) begin
                if (sel == OP_MULT) begin
                    bus.mult_done = 1'b1; bus.mult_hi = rhi; bus.mult_lo = rlo;
                end else begin
                    bus.div_done = 1'b1; bus.div0 = zero; bus.div_hi = rhi; bus.div_lo = rlo;
                end
            end
        end
        bus.op_start = 1'b0;
        @(negedge clk);
    endtask

    int          lat, urc;
    logic        exc, tmo, cb, bb;
    logic [31:0] sa, sb;

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if ({bus.busy, bus.done, bus.div_zero_exc, bus.timeout} !== 4'b0) begin
            n_bad++; $display("FAIL reset_status: got %b want 0000",
                              {bus.busy, bus.done, bus.div_zero_exc, bus.timeout}); end
        n_cmp++; if ({bus.unit_reset, bus.mult_ctrl, bus.div_ctrl} !== 3'b0) begin
            n_bad++; $display("FAIL reset_unit_ctrl: got %b want 000",
                              {bus.unit_reset, bus.mult_ctrl, bus.div_ctrl}); end
        n_cmp++; if ({bus.hi, bus.lo} !== 64'h0) begin
            n_bad++; $display("FAIL reset_hilo: got %h/%h want 0/0", bus.hi, bus.lo); end
        n_cmp++; if ({bus.op_a, bus.op_b} !== 64'h0) begin
            n_bad++; $display("FAIL reset_operands: got %h/%h want 0/0", bus.op_a, bus.op_b); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_div_basic();
        run_op(OP_DIV, 32'd7, 32'd3, 1, 1'b0, 32'd2, 32'd1, 0, lat, urc, exc, tmo, cb, bb, sa, sb);
        n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL div73_latency: got %0d want 4", lat); end
        n_cmp++; if (urc !== 1) begin n_bad++; $display("FAIL div73_clear_pulse: got %0d cycles want 1", urc); end
        n_cmp++; if (exc !== 1'b0) begin n_bad++; $display("FAIL div73_exc: got %b want 0", exc); end
        n_cmp++; if ({cb, bb} !== 2'b00) begin n_bad++; $display("FAIL div73_ctrl_busy: got ctrl_bad=%b busy_bad=%b want 0 0", cb, bb); end
        n_cmp++; if ({sa, sb} !== {32'd7, 32'd3}) begin n_bad++; $display("FAIL div73_operands: got %0d/%0d want 7/3", sa, sb); end
        n_cmp++; if ({bus.done, bus.busy} !== 2'b00) begin n_bad++; $display("FAIL div73_after: got done=%b busy=%b want 0 0", bus.done, bus.busy); end
        n_cmp++; if ({bus.hi, bus.lo} !== {32'd1, 32'd2}) begin n_bad++; $display("FAIL div73_hilo: got %h/%h want 1/2", bus.hi, bus.lo); end
    endtask

    task automatic test_div_negative();
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd3, 5, 1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0,
               lat, urc, exc, tmo, cb, bb, sa, sb);
        n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL divneg_latency: got %0d want 8", lat); end
        n_cmp++; if ({bus.hi, bus.lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFFE}) begin
            n_bad++; $display("FAIL divneg_hilo: got %h/%h want ffffffff/fffffffe", bus.hi, bus.lo); end
    endtask

    task automatic test_div_zero();
        run_op(OP_MULT, 32'd3, 32'd4, 2, 1'b0, 32'd5, 32'd9, 0, lat, urc, exc, tmo, cb, bb, sa, sb);
        n_cmp++; if ({bus.hi, bus.lo} !== {32'd5, 32'd9}) begin n_bad++; $display("FAIL preload_hilo: got %h/%h want 5/9", bus.hi, bus.lo); end
        // Div0 and DivDone together: Div0 must win and garbage results must not land.
        run_op(OP_DIV, 32'd10, 32'd0, 3, 1'b1, 32'hDEAD_0000, 32'h0000_BEEF, 0,
               lat, urc, exc, tmo, cb, bb, sa, sb);
        n_cmp++; if (lat !== 6) begin n_bad++; $display("FAIL div0_latency: got %0d want 6", lat); end
        n_cmp++; if (exc !== 1'b1) begin n_bad++; $display("FAIL div0_exc_with_done: got %b want 1", exc); end
        n_cmp++; if (bus.div_zero_exc !== 1'b0) begin n_bad++; $display("FAIL div0_exc_width: got %b want 0", bus.div_zero_exc); end
        n_cmp++; if ({bus.hi, bus.lo} !== {32'd5, 32'd9}) begin n_bad++; $display("FAIL div0_hilo_kept: got %h/%h want 5/9", bus.hi, bus.lo); end
    endtask

    task automatic test_mult_long();
        run_op(OP_MULT, 32'h1234, 32'h5678, 33, 1'b0, 32'd1, 32'd2, 10,
               lat, urc, exc, tmo, cb, bb, sa, sb);
        n_cmp++; if (lat !== 36) begin n_bad++; $display("FAIL mult33_latency: got %0d want 36", lat); end
        n_cmp++; if ({cb, bb} !== 2'b00) begin n_bad++; $display("FAIL mult33_ctrl_busy: got ctrl_bad=%b busy_bad=%b want 0 0", cb, bb); end
        n_cmp++; if (urc !== 1) begin n_bad++; $display("FAIL mult33_clear_pulse: got %0d want 1", urc); end
        n_cmp++; if ({bus.hi, bus.lo} !== {32'd1, 32'd2}) begin n_bad++; $display("FAIL mult33_hilo: got %h/%h want 1/2", bus.hi, bus.lo); end
        @(negedge clk);
        n_cmp++; if ({bus.busy, bus.unit_reset} !== 2'b00) begin
            n_bad++; $display("FAIL mult33_no_queue: got busy=%b unit_reset=%b want 0 0", bus.busy, bus.unit_reset); end
    endtask

    task automatic test_async_reset();
        bus.op_start = 1'b1; bus.op_sel = OP_DIV; bus.from_a = 32'd50; bus.from_b = 32'd5;
        @(negedge clk); bus.op_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if ({bus.busy, bus.div_ctrl} !== 2'b11) begin n_bad++; $display("FAIL rst_pre_wait: got busy=%b div_ctrl=%b want 1 1", bus.busy, bus.div_ctrl); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if ({bus.busy, bus.div_ctrl, bus.done, bus.unit_reset} !== 4'b0) begin
            n_bad++; $display("FAIL rst_async_ctrl: got %b want 0000", {bus.busy, bus.div_ctrl, bus.done, bus.unit_reset}); end
        n_cmp++; if ({bus.hi, bus.lo, bus.op_a} !== 96'h0) begin
            n_bad++; $display("FAIL rst_async_data: got %h/%h/%h want 0/0/0", bus.hi, bus.lo, bus.op_a); end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        run_op(OP_DIV, 32'd100, 32'd7, 1, 1'b0, 32'd14, 32'd2, 0, lat, urc, exc, tmo, cb, bb, sa, sb);
        n_cmp++; if ({lat, urc} !== {32'd4, 32'd1}) begin n_bad++; $display("FAIL rst_restart: got lat=%0d clear=%0d want 4 1", lat, urc); end
        n_cmp++; if ({bus.hi, bus.lo} !== {32'd2, 32'd14}) begin n_bad++; $display("FAIL rst_restart_hilo: got %h/%h want 2/e", bus.hi, bus.lo); end
    endtask

    task automatic test_back_to_back();
        run_op(OP_DIV, 32'd20, 32'd6, 2, 1'b0, 32'd3, 32'd2, 0, lat, urc, exc, tmo, cb, bb, sa, sb);
        n_cmp++; if ({bus.hi, bus.lo} !== {32'd2, 32'd3}) begin n_bad++; $display("FAIL b2b_first_hilo: got %h/%h want 2/3", bus.hi, bus.lo); end
        run_op(OP_MULT, 32'd9, 32'd4, 1, 1'b0, 32'd0, 32'd36, 0, lat, urc, exc, tmo, cb, bb, sa, sb);
        n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL b2b_second_latency: got %0d want 4", lat); end
        n_cmp++; if ({sa, sb} !== {32'd9, 32'd4}) begin n_bad++; $display("FAIL b2b_operands: got %0d/%0d want 9/4", sa, sb); end
        n_cmp++; if ({bus.hi, bus.lo} !== {32'd0, 32'd36}) begin n_bad++; $display("FAIL b2b_second_hilo: got %h/%h want 0/24", bus.hi, bus.lo); end
    endtask

    task automatic test_timeout();
        run_op(OP_DIV, 32'd1, 32'd1, 1000, 1'b0, 32'd0, 32'd0, 0, lat, urc, exc, tmo, cb, bb, sa, sb);
`ifdef MULDIV_TIMEOUT_EN
        n_cmp++; if (lat !== 19) begin n_bad++; $display("FAIL tmo_latency: got %0d want 19", lat); end
        n_cmp++; if ({tmo, exc} !== 2'b10) begin n_bad++; $display("FAIL tmo_flags: got timeout=%b exc=%b want 1 0", tmo, exc); end
        n_cmp++; if ({bus.hi, bus.lo} !== {32'd0, 32'd36}) begin n_bad++; $display("FAIL tmo_hilo_kept: got %h/%h want 0/24", bus.hi, bus.lo); end
`else
        // Without the watchdog the sequencer must still be waiting, never retiring.
        n_cmp++; if ({lat, bus.busy, bus.timeout} !== {-32'sd1, 2'b10}) begin
            n_bad++; $display("FAIL no_tmo_hold: got lat=%0d busy=%b timeout=%b want -1 1 0", lat, bus.busy, bus.timeout); end
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
`endif
    endtask

    initial begin
        bus.op_start = 1'b0; bus.op_sel = OP_MULT; bus.from_a = '0; bus.from_b = '0;
        bus.mult_done = 1'b0; bus.mult_hi = '0; bus.mult_lo = '0;
        bus.div_done = 1'b0; bus.div0 = 1'b0; bus.div_hi = '0; bus.div_lo = '0;
        test_reset();
        test_div_basic();
        test_div_negative();
        test_div_zero();
        test_mult_long();
        test_async_reset();
        test_back_to_back();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
